// File: rtl/mem_ctrl.sv
// Byte-serial memory arbiter: serves a fetch port and a load/store port over an 8-bit RAM bus,
// load/store first, one byte per cycle, little-endian, with IO-buffer stall, rdy freeze and read flush.
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic        ls_wr,
    input  logic [31:0] ls_addr,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    input  logic        flush,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 8;
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t         state;
    logic [AW-1:0]  addr_q;
    logic [DW-1:0]  wdata_q;
    logic [DW-1:0]  rbuf_q;
    logic [CW-1:0]  len_q;
    logic [CW-1:0]  cnt_q;
    logic           src_ls_q;
    logic           pend_q;
    logic [1:0]     pend_idx_q;
    logic           wr_q;

    logic           io_stall_c;
    logic [CW-1:0]  req_len_c;
    logic [CW-1:0]  next_cnt_c;
    logic [DW-1:0]  rbuf_cap_c;

    // Write strobe must drop in the same cycle as a freeze or a full IO buffer, so it is gated here
    assign io_stall_c = wr_q & io_buffer_full & (mem_a[17:16] == 2'b11);
    assign mem_wr     = wr_q & rdy & ~io_stall_c;
    assign next_cnt_c = cnt_q + CW'(1);

    always_comb begin
        req_len_c = CW'(4);
        case (ls_size)
            2'd0:    req_len_c = CW'(1);
            2'd1:    req_len_c = CW'(2);
            default: req_len_c = CW'(4);
        endcase
    end

    // Read buffer with the byte requested last cycle merged in
    always_comb begin
        rbuf_cap_c = rbuf_q;
        if (pend_q) begin
            rbuf_cap_c[{pend_idx_q, 3'b000} +: BW] = mem_din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rbuf_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            src_ls_q   <= 1'b0;
            pend_q     <= 1'b0;
            pend_idx_q <= '0;
            wr_q       <= 1'b0;
            mem_a      <= '0;
            mem_dout   <= '0;
            if_done    <= 1'b0;
            if_data    <= '0;
            ls_done    <= 1'b0;
            ls_rdata   <= '0;
        end else if (!rdy) begin
            // Frozen: only the byte already on its way back is kept; the held byte is re-issued later
            if (pend_q) begin
                rbuf_q <= rbuf_cap_c;
                pend_q <= 1'b0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (ls_req && (ls_wr || !flush)) begin
                        src_ls_q <= 1'b1;
                        addr_q   <= ls_addr;
                        wdata_q  <= ls_wdata;
                        len_q    <= req_len_c;
                        cnt_q    <= '0;
                        rbuf_q   <= '0;
                        pend_q   <= 1'b0;
                        mem_a    <= ls_addr;
                        if (ls_wr) begin
                            state    <= WRITE;
                            wr_q     <= 1'b1;
                            mem_dout <= ls_wdata[BW-1:0];
                        end else begin
                            state <= READ;
                        end
                    end else if (if_req && !flush) begin
                        src_ls_q <= 1'b0;
                        addr_q   <= if_addr;
                        wdata_q  <= '0;
                        len_q    <= CW'(4);
                        cnt_q    <= '0;
                        rbuf_q   <= '0;
                        pend_q   <= 1'b0;
                        mem_a    <= if_addr;
                        state    <= READ;
                    end
                end
                READ: begin
                    if (flush) begin
                        state  <= IDLE;
                        mem_a  <= '0;
                        cnt_q  <= '0;
                        pend_q <= 1'b0;
                    end else if (cnt_q == len_q) begin
                        state  <= DONE;
                        cnt_q  <= '0;
                        pend_q <= 1'b0;
                        rbuf_q <= rbuf_cap_c;
                        if (src_ls_q) begin
                            ls_done  <= 1'b1;
                            ls_rdata <= rbuf_cap_c;
                        end else begin
                            if_done <= 1'b1;
                            if_data <= rbuf_cap_c;
                        end
                    end else begin
                        rbuf_q     <= rbuf_cap_c;
                        pend_q     <= 1'b1;
                        pend_idx_q <= cnt_q[1:0];
                        cnt_q      <= next_cnt_c;
                        mem_a      <= (next_cnt_c < len_q) ? addr_q + AW'(next_cnt_c) : '0;
                    end
                end
                WRITE: begin
                    if (!io_stall_c) begin
                        if (next_cnt_c < len_q) begin
                            cnt_q    <= next_cnt_c;
                            mem_a    <= addr_q + AW'(next_cnt_c);
                            mem_dout <= wdata_q[{next_cnt_c[1:0], 3'b000} +: BW];
                        end else begin
                            state    <= DONE;
                            cnt_q    <= '0;
                            wr_q     <= 1'b0;
                            mem_a    <= '0;
                            mem_dout <= '0;
                            ls_done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    if_done <= 1'b0;
                    ls_done <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: table of single transactions plus hand-written multi-cycle sequences.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy, flush, io_buffer_full;
    logic        if_req, ls_req, ls_wr;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    logic [1:0]  ls_size;
    logic [7:0]  mem_din;
    logic        if_done, ls_done, mem_wr;
    logic [31:0] if_data, ls_rdata, mem_a;
    logic [7:0]  mem_dout;

    int n_checks = 0;
    int n_errors = 0;
    int wr_count = 0;

    logic [7:0] ram [0:4095];

    typedef struct {
        bit          is_if;
        bit          wr;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp_data;
    } vec_t;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ls_req(ls_req), .ls_wr(ls_wr), .ls_addr(ls_addr), .ls_size(ls_size),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .flush(flush), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
        .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: one cycle read latency, write on the edge when mem_wr is high
    always @(posedge clk) begin
        mem_din <= ram[mem_a[11:0]];
        if (mem_wr) begin
            ram[mem_a[11:0]] <= mem_dout;
            wr_count         <= wr_count + 1;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          n;
        int          done_k;
        bit          other;
        logic [31:0] data;
        logic [31:0] a_exp;
        logic [31:0] sh;
        logic        w_exp;
        logic [7:0]  d_exp;
        logic        own;
        n = v.is_if ? 4 : (v.size == 2'd0 ? 1 : (v.size == 2'd1 ? 2 : 4));
        if (v.is_if) begin
            if_req = 1'b1; if_addr = v.addr;
        end else begin
            ls_req = 1'b1; ls_wr = v.wr; ls_addr = v.addr; ls_size = v.size; ls_wdata = v.wdata;
        end
        done_k = 0; other = 1'b0; data = '0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            a_exp = '0; w_exp = 1'b0; d_exp = '0;
            if (k <= n) begin
                a_exp = v.addr + 32'(k - 1);
                w_exp = v.wr;
                sh    = v.wdata >> (8 * (k - 1));
                d_exp = v.wr ? sh[7:0] : 8'h00;
            end
            chk($sformatf("v%0d_bus_c%0d", idx, k), 64'({mem_a, mem_wr, mem_dout}),
                64'({a_exp, w_exp, d_exp}));
            own = v.is_if ? if_done : ls_done;
            if (v.is_if ? ls_done : if_done) other = 1'b1;
            if (own) begin
                done_k = k;
                data   = v.is_if ? if_data : ls_rdata;
                if_req = 1'b0;
                ls_req = 1'b0;
                break;
            end
        end
        if_req = 1'b0;
        ls_req = 1'b0;
        chk($sformatf("v%0d_done_cycle", idx), 64'(done_k), 64'(v.wr ? n + 1 : n + 2));
        if (!v.wr) chk($sformatf("v%0d_data", idx), 64'(data), 64'(v.exp_data));
        chk($sformatf("v%0d_other_done", idx), 64'(other), 64'(0));
        tick();
        chk($sformatf("v%0d_done_pulse", idx), 64'(v.is_if ? if_done : ls_done), 64'(0));
        if (!v.wr)
            chk($sformatf("v%0d_data_held", idx), 64'(v.is_if ? if_data : ls_rdata), 64'(v.exp_data));
    endtask

    initial begin
        vec_t        vecs [9];
        int          ls_k, if_k, wc0;
        bit          saw_ls;
        logic [31:0] ifd;

        vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 2'd2, 32'h0,         32'h4433_2211};
        vecs[1] = '{1'b0, 1'b0, 32'h0000_0101, 2'd0, 32'h0,         32'h0000_0022};
        vecs[2] = '{1'b0, 1'b0, 32'h0000_0102, 2'd1, 32'h0,         32'h0000_4433};
        vecs[3] = '{1'b0, 1'b1, 32'h0000_0400, 2'd2, 32'hDEAD_BEEF, 32'h0};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_0400, 2'd2, 32'h0,         32'hDEAD_BEEF};
        vecs[5] = '{1'b0, 1'b0, 32'h0000_0400, 2'd3, 32'h0,         32'hDEAD_BEEF};
        vecs[6] = '{1'b0, 1'b1, 32'h0000_0404, 2'd0, 32'h1234_567A, 32'h0};
        vecs[7] = '{1'b0, 1'b0, 32'h0000_0403, 2'd1, 32'h0,         32'h0000_7ADE};
        vecs[8] = '{1'b1, 1'b0, 32'hFFFF_FFFE, 2'd2, 32'h0,         32'h0403_0201};

        for (int i = 0; i < 4096; i++) ram[i] = 8'(i) ^ 8'hA5;
        ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
        ram[12'hFFE] = 8'h01; ram[12'hFFF] = 8'h02; ram[12'h000] = 8'h03; ram[12'h001] = 8'h04;

        rst = 1'b1; rdy = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; ls_req = 1'b0; ls_wr = 1'b0;
        if_addr = '0; ls_addr = '0; ls_wdata = '0; ls_size = '0;
        repeat (2) @(negedge clk);
        chk("rst_bus", 64'({mem_a, mem_wr, mem_dout}), 64'(0));
        chk("rst_dones", 64'({if_done, ls_done}), 64'(0));
        chk("rst_if_data", 64'(if_data), 64'(0));
        chk("rst_ls_rdata", 64'(ls_rdata), 64'(0));
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Simultaneous requests: store half first, fetch after DONE and one IDLE cycle
        if_req = 1'b1; if_addr = 32'h100;
        ls_req = 1'b1; ls_wr = 1'b1; ls_addr = 32'h200; ls_size = 2'd1; ls_wdata = 32'h0000_BEEF;
        ls_k = 0; if_k = 0; ifd = '0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 1) chk("a_byte0", 64'({mem_a, mem_wr, mem_dout}), 64'({32'h200, 1'b1, 8'hEF}));
            if (k == 2) chk("a_byte1", 64'({mem_a, mem_wr, mem_dout}), 64'({32'h201, 1'b1, 8'hBE}));
            if (ls_done && ls_k == 0) begin ls_k = k; ls_req = 1'b0; end
            if (if_done && if_k == 0) begin if_k = k; ifd = if_data; if_req = 1'b0; break; end
        end
        if_req = 1'b0; ls_req = 1'b0;
        chk("a_ls_done_cycle", 64'(ls_k), 64'(3));
        chk("a_if_done_cycle", 64'(if_k), 64'(10));
        chk("a_if_data", 64'(ifd), 64'(32'h4433_2211));
        tick();

        // IO stall: byte store to 0x30000 held for five cycles
        io_buffer_full = 1'b1; wc0 = wr_count; ls_k = 0;
        ls_req = 1'b1; ls_wr = 1'b1; ls_addr = 32'h0003_0000; ls_size = 2'd0; ls_wdata = 32'h0000_005A;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k <= 5) begin
                chk($sformatf("b_stall_c%0d", k), 64'({mem_a, mem_wr}), 64'({32'h0003_0000, 1'b0}));
                if (k == 5) io_buffer_full = 1'b0;
            end
            if (ls_done) begin ls_k = k; ls_req = 1'b0; break; end
        end
        ls_req = 1'b0; io_buffer_full = 1'b0;
        chk("b_done_cycle", 64'(ls_k), 64'(6));
        chk("b_write_count", 64'(wr_count - wc0), 64'(1));
        chk("b_ram_byte", 64'(ram[12'h000]), 64'(8'h5A));
        tick();

        // Flush during second byte of word load, then a fetch blocked by flush, then served
        ls_req = 1'b1; ls_wr = 1'b0; ls_addr = 32'h100; ls_size = 2'd2; saw_ls = 1'b0;
        tick();
        tick();
        chk("c_byte1_addr", 64'(mem_a), 64'(32'h101));
        flush = 1'b1; ls_req = 1'b0; if_req = 1'b1; if_addr = 32'h100;
        tick();
        saw_ls |= ls_done;
        chk("c_idle_after_flush", 64'({mem_a, mem_wr}), 64'(0));
        tick();
        saw_ls |= ls_done;
        chk("c_no_accept_on_flush", 64'(mem_a), 64'(0));
        flush = 1'b0; if_k = 0; ifd = '0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            saw_ls |= ls_done;
            if (if_done) begin if_k = k; ifd = if_data; if_req = 1'b0; break; end
        end
        if_req = 1'b0;
        chk("c_if_done_cycle", 64'(if_k), 64'(6));
        chk("c_if_data", 64'(ifd), 64'(32'h4433_2211));
        chk("c_no_ls_done", 64'(saw_ls), 64'(0));
        tick();

        // rdy low for three edges mid-fetch
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        tick();
        chk("d_pre_freeze", 64'(mem_a), 64'(32'h101));
        rdy = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk($sformatf("d_freeze_c%0d", j), 64'({mem_a, mem_wr, if_done}), 64'({32'h101, 1'b0, 1'b0}));
        end
        rdy = 1'b1; if_k = 0; ifd = '0;
        for (int k = 6; k <= 24; k++) begin
            tick();
            if (if_done) begin if_k = k; ifd = if_data; if_req = 1'b0; break; end
        end
        if_req = 1'b0;
        chk("d_if_done_cycle", 64'(if_k), 64'(9));
        chk("d_if_data", 64'(ifd), 64'(32'h4433_2211));
        tick();

        // Reset pulse mid-write, then a clean fetch
        ls_req = 1'b1; ls_wr = 1'b1; ls_addr = 32'h500; ls_size = 2'd2; ls_wdata = 32'h1122_3344;
        tick();
        tick();
        chk("e_write_active", 64'({mem_a, mem_wr, mem_dout}), 64'({32'h501, 1'b1, 8'h33}));
        rst = 1'b1;
        #1;
        chk("e_rst_bus", 64'({mem_a, mem_wr, mem_dout}), 64'(0));
        chk("e_rst_dones", 64'({if_done, ls_done}), 64'(0));
        chk("e_rst_if_data", 64'(if_data), 64'(0));
        ls_req = 1'b0;
        @(negedge clk);
        rst = 1'b0; if_req = 1'b1; if_addr = 32'h100; saw_ls = 1'b0; if_k = 0; ifd = '0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            saw_ls |= ls_done;
            if (if_done) begin if_k = k; ifd = if_data; if_req = 1'b0; break; end
        end
        if_req = 1'b0;
        chk("e_if_done_cycle", 64'(if_k), 64'(6));
        chk("e_if_data", 64'(ifd), 64'(32'h4433_2211));
        chk("e_no_ls_done", 64'(saw_ls), 64'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
